d_cache_responder: RTL and testbench
====================================

D_CACHE_RESPONDER -- requirements
Module: d_cache_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width; the block ignores addr[1:0].
REQ-002 Parameter DATA_WIDTH, default 32: data word width.
REQ-003 Parameter LSQ_INDEX_WIDTH, default 3: width of the load/store queue dispatch index.
REQ-004 Parameter LINES, default 16, power of 2: direct-mapped lines, one word each; IDX=log2(LINES).
REQ-005 Ports SHALL be as follows, one clock, reset asynchronous active-low:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request present from the load/store queue dispatch stage
i_req_mem_action  in  1  0=READ, 1=WRITE
i_req_addr  in  ADDR_WIDTH  byte address
i_req_data  in  DATA_WIDTH  store data
i_req_bypass_possible  in  1  load satisfied by older store; no cache/memory access
i_req_bypass_data  in  DATA_WIDTH  forwarded store data
i_req_dispatch_index  in  LSQ_INDEX_WIDTH  load queue slot tag
o_dc_miss  out  1  stall; requester holds request stable while high
o_resp_valid  out  1  load result valid
o_resp_dispatch_index  out  LSQ_INDEX_WIDTH  slot of returned load
o_resp_data  out  DATA_WIDTH  load data
o_mem_req_valid  out  1  memory request
o_mem_req_write  out  1  1=write, 0=read
o_mem_req_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0]=0)
o_mem_req_data  out  DATA_WIDTH  write data
i_mem_req_ready  in  1  memory accepts request when valid&ready
i_mem_resp_valid  in  1  read data return
i_mem_resp_data  in  DATA_WIDTH  read data

Function
REQ-006 Index = addr[IDX+1:2]; tag = addr[ADDR_WIDTH-1:IDX+2]; hit = line valid && stored tag equals the request tag.
REQ-007 FSM states SHALL be IDLE, MISS_REQ, MISS_WAIT; requests are examined only in IDLE.
REQ-008 IDLE, valid READ with bypass_possible: o_dc_miss=0; next cycle o_resp_valid=1, o_resp_data=i_req_bypass_data, o_resp_dispatch_index=request index; cache untouched.
REQ-009 IDLE, valid READ, no bypass, hit: o_dc_miss=0; next cycle o_resp_valid=1 with line data and the request index.
REQ-010 IDLE, valid READ, no bypass, miss: o_dc_miss=1 combinationally in the same cycle; next state MISS_REQ; the block latches the address.
REQ-011 MISS_REQ: o_mem_req_valid=1, write=0, latched word address; o_dc_miss=1; on ready go to MISS_WAIT.
REQ-012 MISS_WAIT: o_dc_miss=1; on i_mem_resp_valid the block writes the line (data, tag, valid=1) and goes to IDLE. No response is issued from the fill itself.
REQ-013 After a fill, the still-held request hits in IDLE and is answered per REQ-009. Miss latency from request to o_resp_valid = cycles to ready + wait cycles + 2.
REQ-014 IDLE, valid WRITE (write-through, no-allocate): o_mem_req_valid=1, write=1, word address, i_req_data, all combinational; o_dc_miss = !i_mem_req_ready.
REQ-015 Store accept = WRITE && i_mem_req_ready in IDLE. On a hit, the line data is updated on the accept edge; on a miss, the cache is unchanged. No response is issued.
REQ-016 o_resp_valid SHALL be high exactly one cycle per accepted load and low otherwise; o_resp_* are registered.
REQ-017 o_mem_req_* SHALL remain stable while valid && !ready.
REQ-018 i_mem_resp_valid outside MISS_WAIT SHALL be ignored.
REQ-019 o_dc_miss=0 whenever state is IDLE and (!i_req_valid, bypass read, or hit read).
REQ-020 An index conflict between a fill and the held request's own line is impossible by construction: the fill completes before re-lookup.

Reset
REQ-021 rst_n low SHALL, asynchronously: state=IDLE, all line valid bits=0, o_resp_valid=0, o_resp_dispatch_index=0, o_resp_data=0.
REQ-022 While rst_n is low, o_mem_req_valid=0 and o_dc_miss=0.
REQ-023 Reset in MISS_REQ/MISS_WAIT abandons the miss; any later memory response is ignored per REQ-018.
REQ-024 Tags and line data need no reset.

Verification
REQ-025 After reset, READ 0x40, idx 2, memory ready at once, data 0xDEADBEEF 3 cycles later -> o_dc_miss high 5 cycles, then o_resp_valid 1 cycle with idx 2 and 0xDEADBEEF.
REQ-026 Repeat READ 0x40, idx 5 -> no memory request; o_resp_valid next cycle with 0xDEADBEEF, idx 5.
REQ-027 WRITE 0x40 data 0x12345678 with ready low 2 cycles -> o_dc_miss 2 cycles, mem write to 0x40; then READ 0x40 hits and returns 0x12345678.
REQ-028 READ 0x80, bypass_possible=1, bypass_data 0xCAFE, idx 1 -> no memory access, response next cycle 0xCAFE, idx 1.
REQ-029 READ 0x440 (same index as 0x40, different tag) -> miss, refill evicts 0x40; next READ 0x40 misses.
REQ-030 Assert rst_n during MISS_WAIT, then inject i_mem_resp_valid -> all outputs 0; READ 0x40 afterwards misses.

Source files
------------

// File: rtl/d_cache_responder_if.sv
// Request, response and memory-side signals of the d-cache responder.
// The slave modport is the cache; the master modport is the LSQ/memory side.
interface d_cache_responder_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LSQ_INDEX_WIDTH = 3
);
    logic                       i_req_valid;
    logic                       i_req_mem_action;
    logic [ADDR_WIDTH-1:0]      i_req_addr;
    logic [DATA_WIDTH-1:0]      i_req_data;
    logic                       i_req_bypass_possible;
    logic [DATA_WIDTH-1:0]      i_req_bypass_data;
    logic [LSQ_INDEX_WIDTH-1:0] i_req_dispatch_index;
    logic                       o_dc_miss;
    logic                       o_resp_valid;
    logic [LSQ_INDEX_WIDTH-1:0] o_resp_dispatch_index;
    logic [DATA_WIDTH-1:0]      o_resp_data;
    logic                       o_mem_req_valid;
    logic                       o_mem_req_write;
    logic [ADDR_WIDTH-1:0]      o_mem_req_addr;
    logic [DATA_WIDTH-1:0]      o_mem_req_data;
    logic                       i_mem_req_ready;
    logic                       i_mem_resp_valid;
    logic [DATA_WIDTH-1:0]      i_mem_resp_data;

    modport slave (
        input  i_req_valid, i_req_mem_action, i_req_addr, i_req_data,
               i_req_bypass_possible, i_req_bypass_data, i_req_dispatch_index,
               i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
        output o_dc_miss, o_resp_valid, o_resp_dispatch_index, o_resp_data,
               o_mem_req_valid, o_mem_req_write, o_mem_req_addr, o_mem_req_data
    );

    modport master (
        output i_req_valid, i_req_mem_action, i_req_addr, i_req_data,
               i_req_bypass_possible, i_req_bypass_data, i_req_dispatch_index,
               i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
        input  o_dc_miss, o_resp_valid, o_resp_dispatch_index, o_resp_data,
               o_mem_req_valid, o_mem_req_write, o_mem_req_addr, o_mem_req_data
    );
endinterface

// File: rtl/d_cache_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-allocate data cache that
// answers LSQ loads, forwards bypassed loads and refills on read misses.
module d_cache_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LSQ_INDEX_WIDTH = 3,
    parameter int LINES           = 16
) (
    input logic               clk,
    input logic               rst_n,
    d_cache_responder_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [LINES-1:0]           line_valid_r;
    logic [TAG_W-1:0]           line_tag_r  [LINES];
    logic [DATA_WIDTH-1:0]      line_data_r [LINES];
    logic [ADDR_WIDTH-1:0]      miss_addr_r;
    logic                       resp_valid_r;
    logic [LSQ_INDEX_WIDTH-1:0] resp_index_r;
    logic [DATA_WIDTH-1:0]      resp_data_r;

    logic [IDX_W-1:0]           req_idx_s;
    logic [TAG_W-1:0]           req_tag_s;
    logic [IDX_W-1:0]           fill_idx_s;
    logic [TAG_W-1:0]           fill_tag_s;
    logic [ADDR_WIDTH-1:0]      req_word_addr_s;
    logic                       hit_s;
    logic                       load_accept_s;
    logic [DATA_WIDTH-1:0]      load_data_s;
    logic                       store_hit_we_s;
    logic                       fill_we_s;
    logic                       latch_miss_s;
    logic                       dc_miss_s;
    logic                       mem_valid_s;
    logic                       mem_write_s;
    logic [ADDR_WIDTH-1:0]      mem_addr_s;
    logic [DATA_WIDTH-1:0]      mem_data_s;
    logic                       addr_lsb_unused_s;

    assign req_idx_s         = bus.i_req_addr[IDX_W+1:2];
    assign req_tag_s         = bus.i_req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign req_word_addr_s   = {bus.i_req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign fill_idx_s        = miss_addr_r[IDX_W+1:2];
    assign fill_tag_s        = miss_addr_r[ADDR_WIDTH-1:IDX_W+2];
    assign hit_s             = line_valid_r[req_idx_s] && (line_tag_r[req_idx_s] == req_tag_s);
    assign addr_lsb_unused_s = ^bus.i_req_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, stall and memory-request decode
    always_comb begin
        next_state_s   = state_r;
        dc_miss_s      = 1'b0;
        mem_valid_s    = 1'b0;
        mem_write_s    = 1'b0;
        mem_addr_s     = {ADDR_WIDTH{1'b0}};
        mem_data_s     = {DATA_WIDTH{1'b0}};
        load_accept_s  = 1'b0;
        load_data_s    = {DATA_WIDTH{1'b0}};
        store_hit_we_s = 1'b0;
        fill_we_s      = 1'b0;
        latch_miss_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (bus.i_req_mem_action) begin
                        // Write-through: the store goes straight to memory and stalls until taken
                        mem_valid_s    = 1'b1;
                        mem_write_s    = 1'b1;
                        mem_addr_s     = req_word_addr_s;
                        mem_data_s     = bus.i_req_data;
                        dc_miss_s      = !bus.i_mem_req_ready;
                        store_hit_we_s = bus.i_mem_req_ready && hit_s;
                    end else if (bus.i_req_bypass_possible) begin
                        load_accept_s = 1'b1;
                        load_data_s   = bus.i_req_bypass_data;
                    end else if (hit_s) begin
                        load_accept_s = 1'b1;
                        load_data_s   = line_data_r[req_idx_s];
                    end else begin
                        dc_miss_s    = 1'b1;
                        latch_miss_s = 1'b1;
                        next_state_s = MISS_REQ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            MISS_REQ: begin
                dc_miss_s   = 1'b1;
                mem_valid_s = 1'b1;
                mem_addr_s  = miss_addr_r;
                if (bus.i_mem_req_ready) begin
                    next_state_s = MISS_WAIT;
                end else begin
                    next_state_s = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                dc_miss_s = 1'b1;
                if (bus.i_mem_resp_valid) begin
                    fill_we_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MISS_WAIT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Line valid bits and the latched miss address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_valid_r <= {LINES{1'b0}};
            miss_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (fill_we_s) begin
                line_valid_r[fill_idx_s] <= 1'b1;
            end
            if (latch_miss_s) begin
                miss_addr_r <= req_word_addr_s;
            end
        end
    end

    // Tag and data arrays; a fill and a store hit never coincide
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            line_tag_r[fill_idx_s]  <= fill_tag_s;
            line_data_r[fill_idx_s] <= bus.i_mem_resp_data;
        end else if (store_hit_we_s) begin
            line_data_r[req_idx_s] <= bus.i_req_data;
        end
    end

    // Registered load response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_index_r <= {LSQ_INDEX_WIDTH{1'b0}};
            resp_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            resp_valid_r <= load_accept_s;
            if (load_accept_s) begin
                resp_index_r <= bus.i_req_dispatch_index;
                resp_data_r  <= load_data_s;
            end
        end
    end

    // Stall and memory strobe are forced low while reset is held
    assign bus.o_dc_miss             = dc_miss_s & rst_n;
    assign bus.o_mem_req_valid       = mem_valid_s & rst_n;
    assign bus.o_mem_req_write       = mem_write_s;
    assign bus.o_mem_req_addr        = mem_addr_s;
    assign bus.o_mem_req_data        = mem_data_s;
    assign bus.o_resp_valid          = resp_valid_r;
    assign bus.o_resp_dispatch_index = resp_index_r;
    assign bus.o_resp_data           = resp_data_r;
endmodule

// File: tb/tb_d_cache_responder.sv
// Randomized scoreboard bench for d_cache_responder: a word memory plus a
// tag-only cache model predict stalls and load data.
module tb_d_cache_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LW    = 3;
    localparam int LINES = 16;

    typedef struct {
        logic [LW-1:0] idx;
        logic [DW-1:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    d_cache_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSQ_INDEX_WIDTH(LW)) bus ();
    d_cache_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSQ_INDEX_WIDTH(LW), .LINES(LINES))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] mem_q [int];
    bit            cache_valid [int];
    int unsigned   cache_tag [int];
    resp_t         exp_q [$];
    int            cfg_rdy = -1;
    int            cfg_rd  = -1;
    logic          exp_mem_write;
    logic [AW-1:0] exp_mem_addr;
    logic [DW-1:0] exp_mem_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input int unsigned w);
        if (!mem_q.exists(w)) mem_q[w] = $urandom;
        return mem_q[w];
    endfunction

    // Response monitor: every o_resp_valid cycle must match the oldest accepted load
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: actual idx=%0d data=0x%0h required no response",
                             bus.o_resp_dispatch_index, bus.o_resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_idx", 64'(bus.o_resp_dispatch_index), 64'(e.idx));
                    check("resp_data", 64'(bus.o_resp_data), 64'(e.data));
                end
            end
        end
    end

    // Memory model: random or configured ready/response delays, stray responses when idle
    initial begin : mem_model
        bit            granted, g_write, active, rd_pend;
        int unsigned   g_word, rd_word;
        int            rd_cnt, rdy_cnt;
        logic [DW-1:0] g_data, a_data;
        logic [AW-1:0] a_addr;
        logic          a_write;
        granted = 1'b0; active = 1'b0; rd_pend = 1'b0;
        bus.i_mem_req_ready  = 1'b0;
        bus.i_mem_resp_valid = 1'b0;
        bus.i_mem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.i_mem_resp_valid = 1'b0;
            if (granted) begin
                granted = 1'b0;
                if (g_write) mem_q[g_word] = g_data;
                else begin
                    rd_pend = 1'b1;
                    rd_word = g_word;
                    rd_cnt  = (cfg_rd < 0) ? int'($urandom_range(0, 3)) : cfg_rd;
                end
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.i_mem_resp_valid = 1'b1;
                    bus.i_mem_resp_data  = mem_word(rd_word);
                    rd_pend = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.i_mem_resp_valid = 1'b1;
                bus.i_mem_resp_data  = $urandom;
            end
            if (bus.o_mem_req_valid === 1'b1) begin
                if (!active) begin
                    active  = 1'b1;
                    a_addr  = bus.o_mem_req_addr;
                    a_write = bus.o_mem_req_write;
                    a_data  = bus.o_mem_req_data;
                    rdy_cnt = (cfg_rdy < 0) ? int'($urandom_range(0, 3)) : cfg_rdy;
                    check("mem_req_write", 64'(a_write), 64'(exp_mem_write));
                    check("mem_req_addr", 64'(a_addr), 64'(exp_mem_addr));
                    if (a_write) check("mem_req_data", 64'(a_data), 64'(exp_mem_data));
                end else begin
                    check("mem_req_stable", {bus.o_mem_req_write, bus.o_mem_req_addr, bus.o_mem_req_data},
                          {a_write, a_addr, a_data});
                end
                if (rdy_cnt == 0) begin
                    bus.i_mem_req_ready = 1'b1;
                    granted = 1'b1;
                    g_write = a_write;
                    g_word  = a_addr >> 2;
                    g_data  = a_data;
                    active  = 1'b0;
                end else begin
                    bus.i_mem_req_ready = 1'b0;
                    rdy_cnt--;
                end
            end else begin
                bus.i_mem_req_ready = 1'b0;
                active = 1'b0;
            end
        end
    end

    // Issue one request (called #1 after a rising edge) and hold it until accepted
    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit byp, input logic [DW-1:0] bdata, input logic [LW-1:0] idx,
                          output int miss_cyc);
        int unsigned w, li, tg;
        bit hit;
        int k;
        resp_t e;
        w   = addr >> 2;
        li  = w % LINES;
        tg  = w / LINES;
        hit = cache_valid.exists(li) && (cache_tag[li] == tg);
        exp_mem_write = wr;
        exp_mem_addr  = (!wr && (byp || hit)) ? 32'hFFFF_FFFF : {addr[AW-1:2], 2'b00};
        exp_mem_data  = data;
        bus.i_req_valid           = 1'b1;
        bus.i_req_mem_action      = wr;
        bus.i_req_addr            = addr;
        bus.i_req_data            = data;
        bus.i_req_bypass_possible = byp;
        bus.i_req_bypass_data     = bdata;
        bus.i_req_dispatch_index  = idx;
        miss_cyc = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.o_dc_miss !== 1'b1) break;
            miss_cyc++;
            @(posedge clk);
            #1;
        end
        if (k == 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: actual stall >= 200 cycles required acceptance, addr=0x%0h", addr);
        end else if (!wr) begin
            check("read_stalled", 64'(miss_cyc != 0), 64'(!byp && !hit));
            e.idx  = idx;
            e.data = byp ? bdata : mem_word(w);
            exp_q.push_back(e);
            if (!byp && !hit) begin
                cache_valid[li] = 1'b1;
                cache_tag[li]   = tg;
            end
        end
        @(posedge clk);
        #1;
        bus.i_req_valid          = 1'b0;
        bus.i_req_mem_action     = 1'($urandom);
        bus.i_req_addr           = $urandom;
        bus.i_req_bypass_possible = 1'($urandom);
    endtask

    initial begin : main
        int mc;
        int unsigned tg, li;
        bit wr, byp;
        bus.i_req_valid = 1'b0;
        bus.i_req_mem_action = 1'b0;
        bus.i_req_addr = 32'h0;
        bus.i_req_data = 32'h0;
        bus.i_req_bypass_possible = 1'b0;
        bus.i_req_bypass_data = 32'h0;
        bus.i_req_dispatch_index = 3'd0;
        mem_q[32'h40 >> 2] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        check("rst_resp_idx", 64'(bus.o_resp_dispatch_index), 64'h0);
        check("rst_resp_data", 64'(bus.o_resp_data), 64'h0);
        check("rst_dc_miss", 64'(bus.o_dc_miss), 64'h0);
        check("rst_mem_valid", 64'(bus.o_mem_req_valid), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cfg_rdy = 0; cfg_rd = 2;
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'd2, mc);
        check("fill_miss_cycles", 64'(mc), 64'd5);
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'd5, mc);
        check("hit_miss_cycles", 64'(mc), 64'd0);
        cfg_rdy = 2;
        do_req(1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'h0, 3'd0, mc);
        check("write_stall_cycles", 64'(mc), 64'd2);
        cfg_rdy = 0;
        do_req(1'b0, 32'h42, 32'h0, 1'b0, 32'h0, 3'd3, mc);
        check("write_hit_then_read", 64'(mc), 64'd0);
        check("mem_written", 64'(mem_q[32'h40 >> 2]), 64'h1234_5678);
        do_req(1'b0, 32'h80, 32'h0, 1'b1, 32'h0000_CAFE, 3'd1, mc);
        check("bypass_miss_cycles", 64'(mc), 64'd0);
        cfg_rd = 1;
        do_req(1'b0, 32'h440, 32'h0, 1'b0, 32'h0, 3'd4, mc);
        check("evict_fill_missed", 64'(mc > 0), 64'd1);
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'd6, mc);
        check("evicted_line_missed", 64'(mc > 0), 64'd1);

        // Reset while waiting on a refill of 0x440, with a store held on the bus
        cfg_rd = 6;
        exp_mem_write = 1'b0;
        exp_mem_addr  = 32'h440;
        bus.i_req_valid = 1'b1;
        bus.i_req_mem_action = 1'b0;
        bus.i_req_addr = 32'h440;
        bus.i_req_bypass_possible = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.i_req_mem_action = 1'b1;
        bus.i_req_addr = 32'h100;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        check("mid_rst_resp_idx", 64'(bus.o_resp_dispatch_index), 64'h0);
        check("mid_rst_resp_data", 64'(bus.o_resp_data), 64'h0);
        check("mid_rst_dc_miss", 64'(bus.o_dc_miss), 64'h0);
        check("mid_rst_mem_valid", 64'(bus.o_mem_req_valid), 64'h0);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        rst_n = 1'b1;
        cache_valid.delete();
        repeat (12) @(posedge clk);
        #1;
        cfg_rd = 1;
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'd7, mc);
        check("post_rst_read_missed", 64'(mc > 0), 64'd1);

        cfg_rdy = -1; cfg_rd = -1;
        for (int n = 0; n < 300; n++) begin
            tg  = $urandom_range(0, 3);
            li  = $urandom_range(0, LINES - 1);
            wr  = ($urandom_range(0, 2) == 0);
            byp = !wr && ($urandom_range(0, 4) == 0);
            do_req(wr, 32'((tg << 6) | (li << 2) | $urandom_range(0, 3)), $urandom, byp, $urandom,
                   3'($urandom), mc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
